// File: rtl/grad_seq_pkg.sv
// Shared types and constants for the gradient-mux valve sequencer.
//   state_t      : sequencer phases, in execution order
//   PATH_A/B     : cmd_path encodings (A = ctrl1/ctrl3, B = ctrl2/ctrl4)
//   VALVE_CLOSED : ctrl line level that pressurizes (closes) a valve
package grad_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OPEN_OUT  = 3'd1,
        OPEN_IN   = 3'd2,
        DWELL     = 3'd3,
        CLOSE_IN  = 3'd4,
        CLOSE_OUT = 3'd5
    } state_t;

    localparam logic PATH_A       = 1'b0;
    localparam logic PATH_B       = 1'b1;
    localparam logic VALVE_CLOSED = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/grad_mux_sequencer_seq_timer.sv
// Loadable down-counter shared by the settle and dwell phases.
//   clk, rst : clock, synchronous active-high reset
//   load     : load value into the counter (overrides counting)
//   value    : count to load; the phase lasts value+1 cycles
//   zero     : registered flag, high while the count is zero
module seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_n;

    // Saturates at zero so an idle timer never wraps.
    always_comb begin
        count_n = count_q;
        if (load) begin
            count_n = value;
        end else if (count_q != '0) begin
            count_n = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            zero    <= 1'b1;
        end else begin
            count_q <= count_n;
            zero    <= (count_n == '0);
        end
    end

endmodule

// File: rtl/grad_mux_sequencer.sv
// Break-before-make valve sequencer for the gradient-delivery mux.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_path          : 0 = pair A (ctrl1 in, ctrl3 out), 1 = pair B (ctrl2 in, ctrl4 out)
//   cmd_dwell         : cycles the path stays fully open (0 skips the dwell)
//   abort             : level request to close the current path early
//   ctrl1..ctrl4      : valve pressurize lines, 1 = valve closed
//   busy, done        : sequence in progress / one-cycle end pulse
//   aborted           : qualifies done, sequence saw an abort
//   active_path       : path of the current or last command
module grad_mux_sequencer
    import grad_seq_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_path,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic               ctrl1,
    output logic               ctrl2,
    output logic               ctrl3,
    output logic               ctrl4,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               active_path
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
    localparam int unsigned TW       = max_u(DWELL_W, SETTLE_W);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    state_t             state_q, state_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic               seen_q, seen_n;
    logic               path_n;
    logic               accept;
    logic               t_load;
    logic [TW-1:0]      t_value;
    logic               t_zero;
    logic               outlet_open, inlet_open;
    logic               ctrl1_n, ctrl2_n, ctrl3_n, ctrl4_n;
    logic               done_n;

    seq_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (t_load),
        .value (t_value),
        .zero  (t_zero)
    );

    assign accept = cmd_valid && cmd_ready;

    // Next state, timer loads and next registered outputs.
    always_comb begin
        state_n = state_q;
        t_load  = 1'b0;
        t_value = SETTLE_LD;
        path_n  = active_path;
        dwell_n = dwell_q;
        seen_n  = seen_q;

        if (accept) begin
            path_n  = cmd_path;
            dwell_n = cmd_dwell;
            seen_n  = 1'b0;
        end else if (state_q != IDLE && abort) begin
            seen_n = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = OPEN_OUT;
                    t_load  = 1'b1;
                end
            end
            OPEN_OUT: begin
                // Inlet never opened, so an abort goes straight to closing the outlet.
                if (abort) begin
                    state_n = CLOSE_OUT;
                    t_load  = 1'b1;
                end else if (t_zero) begin
                    state_n = OPEN_IN;
                    t_load  = 1'b1;
                end
            end
            OPEN_IN: begin
                if (abort) begin
                    state_n = CLOSE_IN;
                    t_load  = 1'b1;
                end else if (t_zero) begin
                    t_load = 1'b1;
                    if (dwell_q == '0) begin
                        state_n = CLOSE_IN;
                    end else begin
                        state_n = DWELL;
                        t_value = TW'(dwell_q - DWELL_W'(1));
                    end
                end
            end
            DWELL: begin
                if (abort || t_zero) begin
                    state_n = CLOSE_IN;
                    t_load  = 1'b1;
                end
            end
            CLOSE_IN: begin
                if (t_zero) begin
                    state_n = CLOSE_OUT;
                    t_load  = 1'b1;
                end
            end
            CLOSE_OUT: begin
                if (t_zero) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Valve levels follow the state being entered, so they only move on entry.
        outlet_open = (state_n == OPEN_OUT) || (state_n == OPEN_IN) ||
                      (state_n == DWELL)    || (state_n == CLOSE_IN);
        inlet_open  = (state_n == OPEN_IN)  || (state_n == DWELL);

        ctrl1_n = (inlet_open  && path_n == PATH_A) ? !VALVE_CLOSED : VALVE_CLOSED;
        ctrl2_n = (inlet_open  && path_n == PATH_B) ? !VALVE_CLOSED : VALVE_CLOSED;
        ctrl3_n = (outlet_open && path_n == PATH_A) ? !VALVE_CLOSED : VALVE_CLOSED;
        ctrl4_n = (outlet_open && path_n == PATH_B) ? !VALVE_CLOSED : VALVE_CLOSED;

        done_n = (state_q == CLOSE_OUT) && (state_n == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dwell_q     <= '0;
            seen_q      <= 1'b0;
            active_path <= PATH_A;
            ctrl1       <= VALVE_CLOSED;
            ctrl2       <= VALVE_CLOSED;
            ctrl3       <= VALVE_CLOSED;
            ctrl4       <= VALVE_CLOSED;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state_q     <= state_n;
            dwell_q     <= dwell_n;
            seen_q      <= seen_n;
            active_path <= path_n;
            ctrl1       <= ctrl1_n;
            ctrl2       <= ctrl2_n;
            ctrl3       <= ctrl3_n;
            ctrl4       <= ctrl4_n;
            cmd_ready   <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            done        <= done_n;
            aborted     <= done_n && seen_n;
        end
    end

endmodule

// File: tb/tb_grad_mux_sequencer.sv
// Scoreboard bench for grad_mux_sequencer: the driver pushes expected done
// records and per-cycle valve/busy probes when a command is accepted; the
// monitor pops and compares them as the DUT produces them.
module tb_grad_mux_sequencer;
    import grad_seq_pkg::*;

    localparam int unsigned S  = 2;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_path;
    logic [DW-1:0] cmd_dwell;
    logic          abort;
    logic          ctrl1, ctrl2, ctrl3, ctrl4;
    logic          busy, done, aborted, active_path;

    grad_mux_sequencer #(.SETTLE(S), .DWELL_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_path    (cmd_path),
        .cmd_dwell   (cmd_dwell),
        .abort       (abort),
        .ctrl1       (ctrl1),
        .ctrl2       (ctrl2),
        .ctrl3       (ctrl3),
        .ctrl4       (ctrl4),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .active_path (active_path)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int   cyc;
        logic ab;
        logic path;
    } done_exp_t;

    typedef struct {
        int         cyc;
        logic [4:0] v;   // {busy, ctrl1, ctrl2, ctrl3, ctrl4}
    } probe_t;

    done_exp_t dq[$];
    probe_t    pq[$];
    int        total = 0;
    int        bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: phases relative to the accept cycle, with an optional single abort pulse at rel a.
    task automatic model(input int s, input int d, input int a,
                         output int done_rel, output int co_start, output int ci_start,
                         output logic ab);
        if (a >= 1 && a <= s) begin
            co_start = a + 1;
            ci_start = s + 1;
            done_rel = a + s + 1;
        end else if (a > s && a <= 2*s + d) begin
            ci_start = a + 1;
            co_start = a + s + 1;
            done_rel = a + 2*s + 1;
        end else begin
            ci_start = 2*s + d + 1;
            co_start = 3*s + d + 1;
            done_rel = 4*s + d + 1;
        end
        ab = (a >= 1 && a < done_rel);
    endtask

    // Issue one command; returns in its done cycle (positioned #1 after the edge).
    task automatic run_cmd(input logic path, input int dwell, input int a, input bit hold_next,
                           output int t_acc);
        int   done_rel, co_start, ci_start;
        logic ab;
        bit   got;
        logic out_o, in_o;
        cmd_valid = 1'b1;
        cmd_path  = path;
        cmd_dwell = DW'(dwell);
        abort     = 1'b0;
        got       = 1'b0;
        t_acc     = -1;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got   = 1'b1;
                t_acc = cyc;
            end else begin
                @(posedge clk) #1;
            end
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        model(S, dwell, a, done_rel, co_start, ci_start, ab);
        dq.push_back('{t_acc + done_rel, ab, path});
        for (int r = 1; r <= done_rel; r++) begin
            out_o = (r < co_start);
            in_o  = (r >= S + 1) && (r < ci_start);
            pq.push_back('{t_acc + r, {r < done_rel,
                                       !(in_o  && path == PATH_A),
                                       !(in_o  && path == PATH_B),
                                       !(out_o && path == PATH_A),
                                       !(out_o && path == PATH_B)}});
        end
        @(posedge clk) #1;
        if (hold_next) begin
            cmd_path  = ~path;
            cmd_dwell = DW'(4);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int r = 1; r < done_rel; r++) begin
            abort = (r == a);
            @(posedge clk) #1;
        end
        abort = 1'b0;
    endtask

    // Monitor: scoreboard pops, probes and valve invariants.
    logic [3:0] prev_ctrl  = 4'hF;
    state_t     prev_state = IDLE;
    always @(negedge clk) begin
        done_exp_t e;
        if (done) begin
            if (dq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
            end else begin
                e = dq.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("aborted", 32'(aborted), 32'(e.ab));
                check("active_path", 32'(active_path), 32'(e.path));
            end
        end
        while (pq.size() != 0 && pq[0].cyc <= cyc) begin
            check("busy_ctrl", 32'({busy, ctrl1, ctrl2, ctrl3, ctrl4}), 32'(pq[0].v));
            void'(pq.pop_front());
        end
        if (!ctrl1 && !ctrl2) begin
            bad++;
            $display("FAIL inv_both_inlets at cycle %0d: got ctrl1=0 ctrl2=0 expected not both 0", cyc);
        end
        if ((!ctrl1 && ctrl3) || (!ctrl2 && ctrl4)) begin
            bad++;
            $display("FAIL inv_inlet_outlet at cycle %0d: got ctrl=%b expected outlet open under open inlet",
                     cyc, {ctrl1, ctrl2, ctrl3, ctrl4});
        end
        if ({ctrl1, ctrl2, ctrl3, ctrl4} != prev_ctrl && dut.state_q == prev_state) begin
            bad++;
            $display("FAIL inv_ctrl_on_entry at cycle %0d: got ctrl change %b->%b expected only on state entry",
                     cyc, prev_ctrl, {ctrl1, ctrl2, ctrl3, ctrl4});
        end
        prev_ctrl  = {ctrl1, ctrl2, ctrl3, ctrl4};
        prev_state = dut.state_q;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        int d, a;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_path  = 1'b0;
        cmd_dwell = '0;
        abort     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl",    32'({ctrl1, ctrl2, ctrl3, ctrl4}), 32'hF);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_ready",   32'(cmd_ready), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_path",    32'(active_path), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk) #1;

        // Nominal paths, dwell skip, aborts in each phase, max dwell.
        run_cmd(PATH_A, 5,   0,  1'b0, t1);
        run_cmd(PATH_B, 0,   0,  1'b0, t1);
        run_cmd(PATH_A, 100, 20, 1'b0, t1);
        run_cmd(PATH_B, 10,  1,  1'b0, t1);
        run_cmd(PATH_A, 10,  3,  1'b0, t1);
        run_cmd(PATH_B, 3,   8,  1'b0, t1);
        run_cmd(PATH_A, 255, 0,  1'b0, t1);

        // Back-to-back: second command held valid through the first sequence.
        run_cmd(PATH_A, 3, 0, 1'b1, t1);
        run_cmd(PATH_B, 4, 0, 1'b0, t2);
        check("b2b_accept_cycle", t2, t1 + 4*S + 3 + 1);

        // Reset mid-DWELL: ctrl closes at the next edge, no done afterwards.
        cmd_valid = 1'b1;
        cmd_path  = PATH_A;
        cmd_dwell = DW'(50);
        @(negedge clk);
        check("rst_test_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk) #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_dwell_ctrl", 32'({ctrl1, ctrl2, ctrl3, ctrl4}), 32'b0101);
        @(posedge clk) #1;
        @(negedge clk);
        check("midrst_ctrl",  32'({ctrl1, ctrl2, ctrl3, ctrl4}), 32'hF);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;
        @(negedge clk);
        check("ready_after_midrst", 32'(cmd_ready), 32'd1);
        check("busy_after_midrst",  32'(busy), 32'd0);
        @(posedge clk) #1;

        // Random commands, half with a single abort pulse anywhere in the sequence.
        while (cyc < 11000) begin
            d = int'($urandom_range(0, 12));
            a = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4*S + d));
            run_cmd(logic'($urandom_range(0, 1)), d, a, 1'b0, t1);
            repeat ($urandom_range(0, 2)) @(posedge clk) #1;
        end

        repeat (4) @(posedge clk) #1;
        @(negedge clk);
        check("dq_drained", 32'(dq.size()), 32'd0);
        check("pq_drained", 32'(pq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grad_mux_sequencer.md
# grad_mux_sequencer

Pneumatic control sequencer directly upstream of the gradient-delivery multiplexer. It drives the four valve-control lines of the mux (ctrl1..ctrl4), routing gradient-generator output to one of two trap pairs. Each routing command is executed as a break-before-make valve sequence with programmable settle and dwell times. It guarantees that no inlet valve opens while its downstream valve is closed, and that both inlet valves are never open together.

## Interface
Parameters:
- SETTLE, 4, cycles held after every single valve transition (must be ≥1)
- DWELL_W, 16, width of the dwell-count field

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_path  in  1  0 = pair A (ctrl1 inlet, ctrl3 outlet), 1 = pair B (ctrl2 inlet, ctrl4 outlet)
- cmd_dwell  in  DWELL_W  cycles the path stays fully open
- abort  in  1  request early close of the current path
- ctrl1, ctrl2, ctrl3, ctrl4  out  1 each  valve pressurize lines; 1 = pressurized = valve closed
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- aborted  out  1  qualifies done; 1 when the sequence ended via abort
- active_path  out  1  path of the current/last command

## Operation
- Reset is synchronous and active-high: state IDLE; ctrl1..ctrl4 = 1 (all closed); cmd_ready = 0 during rst, then 1; busy = 0, done = 0, aborted = 0, active_path = 0.
- Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE. cmd_path and cmd_dwell are latched at acceptance.
- States:
  - IDLE
  - OPEN_OUT: outlet valve = 0; SETTLE cycles
  - OPEN_IN: inlet valve = 0; SETTLE cycles
  - DWELL: cmd_dwell cycles, skipped entirely when cmd_dwell = 0
  - CLOSE_IN: inlet valve = 1; SETTLE cycles
  - CLOSE_OUT: outlet valve = 1; SETTLE cycles
  - then IDLE
- Only the latched path's valves ever move. The other path's ctrl lines stay 1.
- Abort (level-sampled each cycle):
  - OPEN_OUT → CLOSE_OUT
  - OPEN_IN or DWELL → CLOSE_IN
  - ignored in CLOSE_IN, CLOSE_OUT and IDLE
  - any abort seen during the sequence sets aborted at done
- Invariants (assert in bench):
  - inlet = 0 implies the same path's outlet = 0
  - ctrl1 and ctrl2 never both 0
  - ctrl1..ctrl4 change only on state entry
- busy = 1 in every state except IDLE.
- done pulses in the first IDLE cycle after CLOSE_OUT.
- rst mid-sequence: all ctrl lines return to 1 on the next edge; no done pulse.

## Timing
- All outputs are registered.
- Accept at edge T (state S = SETTLE, dwell D):
  - OPEN_OUT: cycles T+1..T+S
  - OPEN_IN: T+S+1..T+2S
  - DWELL: T+2S+1..T+2S+D
  - CLOSE_IN: T+2S+D+1..T+3S+D
  - CLOSE_OUT: T+3S+D+1..T+4S+D
  - done = 1 and cmd_ready = 1 at T+4S+D+1
- Accept-to-done latency is 4S+D+1 cycles.
- A new command may be accepted in the done cycle.
- Abort sampled in cycle k moves the state at edge k+1. The close phases then take their full S cycles each.
- Dwell counter is DWELL_W bits and counts down. The maximum dwell (2^DWELL_W−1) must not wrap.

## Structure
- Package grad_seq_pkg holds:
  - the state enum (IDLE, OPEN_OUT, OPEN_IN, DWELL, CLOSE_IN, CLOSE_OUT)
  - PATH_A = 0, PATH_B = 1
  - the valve-closed constant VALVE_CLOSED = 1
- One sub-module, seq_timer: a loadable down-counter of width max(DWELL_W, clog2(SETTLE+1)) with load, value and zero flag. It is shared by the settle and dwell phases.

## Test plan
- Reset: hold rst 3 cycles mid-DWELL → next edge ctrl1..4 = 1111, busy = 0, no done, cmd_ready = 1 after rst drops.
- S = 2, path 0, D = 5, accept at T → ctrl3 = 0 at T+1, ctrl1 = 0 at T+3, ctrl1 = 1 at T+10, ctrl3 = 1 at T+12, done = 1 with aborted = 0 at T+14; ctrl2 and ctrl4 stay 1 throughout.
- S = 2, path 1, D = 0 → DWELL skipped; ctrl2 open only during T+3..T+4; done at T+9.
- S = 2, path 0, D = 100, abort pulsed at T+20 → ctrl1 = 1 at T+21, ctrl3 = 1 at T+23, done with aborted = 1 at T+25.
- Back-to-back: second command (path 1) held valid during the first sequence → accepted exactly in the first command's done cycle; ctrl1 and ctrl2 are never simultaneously 0.
- Randomized commands with random aborts over 10k cycles → invariant assertions never fire; every accept is followed by exactly one done.
